tl_rx_error_check_aer_logger: RTL and testbench

//  Parametrised successor to the RX error-check priority encoder. Takes NUM_ERR_SRC per-TLP error flags from the RX check sub-blocks
//  (overflow, FC, malformed, ECRC, UR, UC, poisoned, ...). Reports a prioritised error type and the DLL discard request.

---
 rtl/tl_rx_error_check_aer_logger_if.sv | 27 ++
 rtl/tl_rx_error_check_aer_logger.sv | 255 +++++++++++++++++++++++++
 tb/tb_tl_rx_error_check_aer_logger.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_rx_error_check_aer_logger_if.sv
`default_nettype none
// ============================================================================
//  Module      : tl_rx_error_check_aer_logger_if
//  Description : Severity-message channel between the RX error logger and the
//                TX message generator (valid/ready handshake).
//  Revision    : 1.0 - initial release
// ============================================================================
interface tl_rx_error_check_aer_logger_if;
    logic       o_msg_valid;   // queue head holds a message
    logic [1:0] o_msg_sev;     // head severity: 00 cor, 01 non-fatal, 10 fatal
    logic       i_msg_ready;   // TX message generator accepts the head

    // Logger side: produces messages
    modport master (
        output o_msg_valid,
        output o_msg_sev,
        input  i_msg_ready
    );

    // TX message generator side: consumes messages
    modport slave (
        input  o_msg_valid,
        input  o_msg_sev,
        output i_msg_ready
    );
endinterface
`default_nettype wire

// File: rtl/tl_rx_error_check_aer_logger.sv
`default_nettype none
// ============================================================================
//  Module      : tl_rx_error_check_aer_logger
//  Description : RX TLP error-check priority encoder with AER-style logging:
//                per-source mask/severity, sticky RW1C status, first-error
//                pointer with header log, and a buffered severity-message
//                queue towards the TX message generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_rx_error_check_aer_logger #(
    parameter int NUM_ERR_SRC    = 7,
    parameter int HDR_LOG_WIDTH  = 128,
    parameter int MSG_FIFO_DEPTH = 4,
    parameter int TYPE_W         = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_error_check_en,
    input  logic [NUM_ERR_SRC-1:0]     i_error_vec,
    input  logic [HDR_LOG_WIDTH-1:0]   i_hdr_log,
    input  logic                       i_dll_rx_eop,
    input  logic [NUM_ERR_SRC-1:0]     i_err_mask,
    input  logic [2*NUM_ERR_SRC-1:0]   i_err_sev,
    input  logic [2:0]                 i_sev_report_en,
    input  logic [NUM_ERR_SRC-1:0]     i_status_clr,
    input  logic                       i_log_clr,
    output logic                       o_error_check,
    output logic [TYPE_W-1:0]          o_error_type,
    output logic                       o_dll_rx_tlp_discard,
    output logic [NUM_ERR_SRC-1:0]     o_err_status,
    output logic                       o_log_valid,
    output logic [TYPE_W-1:0]          o_first_err_ptr,
    output logic [HDR_LOG_WIDTH-1:0]   o_hdr_log,
    output logic                       o_msg_overflow,
    tl_rx_error_check_aer_logger_if.master msg_if
);

    localparam int c_AW = $clog2(MSG_FIFO_DEPTH);

    typedef enum logic [0:0] {
        LOG_IDLE = 1'b0,
        LOG_HELD = 1'b1
    } log_state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [TYPE_W-1:0]          w_type;
    logic [NUM_ERR_SRC-1:0]     w_fatal_src;
    logic [NUM_ERR_SRC-1:0]     w_nonfat_src;
    logic [NUM_ERR_SRC-1:0]     w_u;
    logic [NUM_ERR_SRC-1:0]     w_unc_u;
    logic                       w_unc_any;
    logic [TYPE_W-1:0]          w_first_idx;
    logic                       w_any_fatal;
    logic                       w_any_nonfat;
    logic [1:0]                 w_msg_sev;
    logic                       w_msg_req;

    logic [NUM_ERR_SRC-1:0]     r_status;

    log_state_t                 r_log_state;
    log_state_t                 w_log_next;
    logic                       w_capture;
    logic                       w_release;
    logic [TYPE_W-1:0]          r_first_ptr;
    logic [HDR_LOG_WIDTH-1:0]   r_hdr_log;

    logic [1:0]                 r_mem [MSG_FIFO_DEPTH];
    logic [c_AW:0]              r_wr_ptr;
    logic [c_AW:0]              r_rd_ptr;
    logic                       r_overflow;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_drop;

    // ------------------------------------------------------------------------
    // Combinational error report: lowest asserted index wins, mask ignored
    // ------------------------------------------------------------------------
    always_comb begin
        w_type = '0;
        for (int i = NUM_ERR_SRC - 1; i >= 0; i--) begin
            if (i_error_vec[i]) begin
                w_type = TYPE_W'(i + 1);
            end
        end
    end

    assign o_error_check        = i_error_check_en & (|i_error_vec);
    assign o_error_type         = i_error_check_en ? w_type : '0;
    assign o_dll_rx_tlp_discard = o_error_check & ~i_dll_rx_eop;

    // ------------------------------------------------------------------------
    // Per-source severity decode (11 is treated as fatal)
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_ERR_SRC; g++) begin : g_sev
        assign w_fatal_src[g]  = i_err_sev[2*g+1];
        assign w_nonfat_src[g] = (i_err_sev[2*g+1 -: 2] == 2'b01);
    end

    assign w_u          = i_error_vec & ~i_err_mask & {NUM_ERR_SRC{i_error_check_en}};
    assign w_unc_u      = w_u & (w_fatal_src | w_nonfat_src);
    assign w_unc_any    = |w_unc_u;
    assign w_any_fatal  = |(w_u & w_fatal_src);
    assign w_any_nonfat = |(w_u & w_nonfat_src);

    // Lowest-index uncorrectable unmasked source, candidate for the log
    always_comb begin
        w_first_idx = '0;
        for (int i = NUM_ERR_SRC - 1; i >= 0; i--) begin
            if (w_unc_u[i]) begin
                w_first_idx = TYPE_W'(i);
            end
        end
    end

    // One message per TLP at its highest unmasked severity, if reporting enabled
    always_comb begin
        w_msg_sev = 2'b00;
        w_msg_req = 1'b0;
        if (w_any_fatal) begin
            w_msg_sev = 2'b10;
            w_msg_req = i_sev_report_en[2];
        end else if (w_any_nonfat) begin
            w_msg_sev = 2'b01;
            w_msg_req = i_sev_report_en[1];
        end else if (|w_u) begin
            w_msg_sev = 2'b00;
            w_msg_req = i_sev_report_en[0];
        end
    end

    // ------------------------------------------------------------------------
    // Sticky status: new errors set, RW1C strobes clear, set beats clear
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_status <= '0;
        end else if (i_error_check_en) begin
            r_status <= (r_status & ~i_status_clr) | i_error_vec;
        end else begin
            r_status <= r_status & ~i_status_clr;
        end
    end

    assign o_err_status = r_status;

    // ------------------------------------------------------------------------
    // Log FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_log_state <= LOG_IDLE;
        end else begin
            r_log_state <= w_log_next;
        end
    end

    // Log FSM next state: capture when idle, or when released with a new error
    always_comb begin
        w_log_next = r_log_state;
        w_capture  = 1'b0;
        w_release  = 1'b0;
        case (r_log_state)
            LOG_IDLE: begin
                if (w_unc_any) begin
                    w_capture  = 1'b1;
                    w_log_next = LOG_HELD;
                end
            end
            LOG_HELD: begin
                if (i_log_clr) begin
                    if (w_unc_any) begin
                        w_capture  = 1'b1;
                        w_log_next = LOG_HELD;
                    end else begin
                        w_release  = 1'b1;
                        w_log_next = LOG_IDLE;
                    end
                end
            end
            default: begin
                w_log_next = LOG_IDLE;
            end
        endcase
    end

    // First-error pointer and header; zeroed when the log is released
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_first_ptr <= '0;
            r_hdr_log   <= '0;
        end else if (w_capture) begin
            r_first_ptr <= w_first_idx;
            r_hdr_log   <= i_hdr_log;
        end else if (w_release) begin
            r_first_ptr <= '0;
            r_hdr_log   <= '0;
        end
    end

    assign o_log_valid     = (r_log_state == LOG_HELD);
    assign o_first_err_ptr = r_first_ptr;
    assign o_hdr_log       = r_hdr_log;

    // ------------------------------------------------------------------------
    // Message FIFO: wrap-bit pointers; a push into a full queue survives only
    // when the head is popped on the same edge
    // ------------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = ~w_empty & msg_if.i_msg_ready;
    assign w_push  = w_msg_req & (~w_full | w_pop);
    assign w_drop  = w_msg_req & w_full & ~w_pop;

    // Message storage write
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_msg_sev;
        end
    end

    // Read/write pointer update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
            end
        end
    end

    // Sticky drop indicator, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_msg_overflow     = r_overflow;
    assign msg_if.o_msg_valid = ~w_empty;
    assign msg_if.o_msg_sev   = w_empty ? 2'b00 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_tl_rx_error_check_aer_logger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tl_rx_error_check_aer_logger
//  Description : Self-checking bench for tl_rx_error_check_aer_logger with a
//                behavioural reference model and directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_rx_error_check_aer_logger;

    logic         clk;
    logic         rst;
    logic         en;
    logic [6:0]   vec;
    logic [127:0] hdr;
    logic         eop;
    logic [6:0]   mask;
    logic [13:0]  sev;
    logic [2:0]   sev_en;
    logic [6:0]   clr;
    logic         log_clr;
    logic         ready;

    logic         o_error_check;
    logic [2:0]   o_error_type;
    logic         o_discard;
    logic [6:0]   o_err_status;
    logic         o_log_valid;
    logic [2:0]   o_first_err_ptr;
    logic [127:0] o_hdr_log;
    logic         o_msg_overflow;

    tl_rx_error_check_aer_logger_if msg_bus ();
    assign msg_bus.i_msg_ready = ready;

    tl_rx_error_check_aer_logger #(
        .NUM_ERR_SRC    (7),
        .HDR_LOG_WIDTH  (128),
        .MSG_FIFO_DEPTH (4),
        .TYPE_W         (3)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_error_check_en     (en),
        .i_error_vec          (vec),
        .i_hdr_log            (hdr),
        .i_dll_rx_eop         (eop),
        .i_err_mask           (mask),
        .i_err_sev            (sev),
        .i_sev_report_en      (sev_en),
        .i_status_clr         (clr),
        .i_log_clr            (log_clr),
        .o_error_check        (o_error_check),
        .o_error_type         (o_error_type),
        .o_dll_rx_tlp_discard (o_discard),
        .o_err_status         (o_err_status),
        .o_log_valid          (o_log_valid),
        .o_first_err_ptr      (o_first_err_ptr),
        .o_hdr_log            (o_hdr_log),
        .o_msg_overflow       (o_msg_overflow),
        .msg_if               (msg_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit run      = 1'b0;

    // Reference model state
    logic [6:0]   m_status;
    bit           m_lv;
    logic [2:0]   m_ptr;
    logic [127:0] m_hdr;
    bit [1:0]     m_q[$];
    bit           m_ovf;

    localparam logic [127:0] H1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1111_2222;
    localparam logic [127:0] H2 = 128'hCAFE_F00D_5555_AAAA_0F0F_F0F0_3333_4444;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs applied for it
    task automatic model_update();
        logic [6:0] u;
        int first;
        int top;
        int s;
        if (rst) begin
            m_status = '0; m_lv = 1'b0; m_ptr = '0; m_hdr = '0; m_ovf = 1'b0;
            m_q.delete();
            return;
        end
        u = en ? (vec & ~mask) : 7'b0;
        m_status = en ? ((m_status & ~clr) | vec) : (m_status & ~clr);
        first = -1;
        top   = -1;
        for (int i = 0; i < 7; i++) begin
            if (u[i]) begin
                s = (sev[2*i +: 2] == 2'b00) ? 0 : (sev[2*i +: 2] == 2'b01) ? 1 : 2;
                if (s > top) top = s;
                if (s > 0 && first < 0) first = i;
            end
        end
        if (first >= 0 && (!m_lv || log_clr)) begin
            m_lv = 1'b1; m_ptr = first[2:0]; m_hdr = hdr;
        end else if (log_clr) begin
            m_lv = 1'b0; m_ptr = '0; m_hdr = '0;
        end
        if (m_q.size() > 0 && ready) void'(m_q.pop_front());
        if (top >= 0 && sev_en[top]) begin
            if (m_q.size() < 4) m_q.push_back((top == 2) ? 2'b10 : (top == 1) ? 2'b01 : 2'b00);
            else m_ovf = 1'b1;
        end
    endtask

    // Compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        logic [2:0] t;
        if (run) begin
            t = 3'd0;
            for (int i = 6; i >= 0; i--) if (vec[i]) t = 3'(i + 1);
            if (!en) t = 3'd0;
            chk("error_check", {127'b0, o_error_check}, {127'b0, en & (|vec)});
            chk("error_type", {125'b0, o_error_type}, {125'b0, t});
            chk("discard", {127'b0, o_discard}, {127'b0, en & (|vec) & ~eop});
            chk("err_status", {121'b0, o_err_status}, {121'b0, m_status});
            chk("log_valid", {127'b0, o_log_valid}, {127'b0, m_lv});
            chk("first_err_ptr", {125'b0, o_first_err_ptr}, {125'b0, m_ptr});
            chk("hdr_log", o_hdr_log, m_hdr);
            chk("msg_valid", {127'b0, msg_bus.o_msg_valid}, {127'b0, m_q.size() > 0});
            chk("msg_sev", {126'b0, msg_bus.o_msg_sev}, {126'b0, (m_q.size() > 0) ? m_q[0] : 2'b00});
            chk("msg_overflow", {127'b0, o_msg_overflow}, {127'b0, m_ovf});
        end
    end

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vec = '0; hdr = '0; eop = 1'b0; mask = '0;
        sev = '0; sev_en = 3'b111; clr = '0; log_clr = 1'b0; ready = 1'b1;
        tick();
        run = 1'b1;
        chk("reset_status", {121'b0, o_err_status}, 128'd0);
        chk("reset_log_valid", {127'b0, o_log_valid}, 128'd0);
        chk("reset_msg_valid", {127'b0, msg_bus.o_msg_valid}, 128'd0);
        chk("reset_overflow", {127'b0, o_msg_overflow}, 128'd0);
        rst = 1'b0;
        tick();

        // Priority encode and discard
        en = 1'b1; vec = 7'b0010100; eop = 1'b0;
        #2;
        chk("t1_type", {125'b0, o_error_type}, 128'd3);
        chk("t1_check", {127'b0, o_error_check}, 128'd1);
        chk("t1_discard_eop0", {127'b0, o_discard}, 128'd1);
        eop = 1'b1;
        #1;
        chk("t1_discard_eop1", {127'b0, o_discard}, 128'd0);
        tick();
        chk("t1_status", {121'b0, o_err_status}, 128'b0010100);
        chk("t1_cor_msg", {126'b0, msg_bus.o_msg_sev}, 128'd0);
        eop = 1'b0; vec = '0; clr = 7'h7f;
        tick();
        chk("t1_status_cleared", {121'b0, o_err_status}, 128'd0);
        clr = '0;

        // First-error log keeps the first uncorrectable error
        sev = '0; sev[9:8] = 2'b01; sev[3:2] = 2'b10;
        vec = 7'b0010000; hdr = H1;
        tick();
        vec = 7'b0000010; hdr = H2;
        tick();
        en = 1'b0; vec = '0;
        tick();
        chk("t2_ptr", {125'b0, o_first_err_ptr}, 128'd4);
        chk("t2_hdr", o_hdr_log, H1);
        chk("t2_status", {121'b0, o_err_status}, 128'b0010010);
        chk("t2_log_valid", {127'b0, o_log_valid}, 128'd1);
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
        chk("t2_released", {127'b0, o_log_valid}, 128'd0);
        en = 1'b1; vec = 7'b0010000; hdr = H1;
        tick();
        log_clr = 1'b1; vec = 7'b0000010; hdr = H2;
        tick();
        chk("t2_clr_recapture_ptr", {125'b0, o_first_err_ptr}, 128'd1);
        chk("t2_clr_recapture_hdr", o_hdr_log, H2);
        en = 1'b0; vec = '0;
        tick();
        log_clr = 1'b0;

        // Masked fatal source: status and type only
        en = 1'b1; clr = 7'h7f;
        tick();
        clr = '0; mask = 7'b0000001; sev = 14'b10; vec = 7'b0000001;
        #2;
        chk("t3_type", {125'b0, o_error_type}, 128'd1);
        tick();
        en = 1'b0; vec = '0; mask = '0;
        chk("t3_status", {121'b0, o_err_status}, 128'b0000001);
        chk("t3_log_valid", {127'b0, o_log_valid}, 128'd0);
        chk("t3_msg_valid", {127'b0, msg_bus.o_msg_valid}, 128'd0);

        // Queue fill with overflow, then drain
        ready = 1'b0; sev = {7{2'b10}}; en = 1'b1; vec = 7'b0001000;
        repeat (5) tick();
        en = 1'b0; vec = '0;
        chk("t4_valid", {127'b0, msg_bus.o_msg_valid}, 128'd1);
        chk("t4_overflow", {127'b0, o_msg_overflow}, 128'd1);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_pop_sev", {126'b0, msg_bus.o_msg_sev}, 128'b10);
            tick();
        end
        chk("t4_drained", {127'b0, msg_bus.o_msg_valid}, 128'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_ovf_reset", {127'b0, o_msg_overflow}, 128'd0);

        // Push into full queue with simultaneous pop
        ready = 1'b0; en = 1'b1; vec = 7'b0001000;
        repeat (4) tick();
        ready = 1'b1; sev = 14'h0040;
        tick();
        en = 1'b0; vec = '0;
        chk("t5_overflow", {127'b0, o_msg_overflow}, 128'd0);
        for (int k = 0; k < 3; k++) begin
            chk("t5_pop_sev", {126'b0, msg_bus.o_msg_sev}, 128'b10);
            tick();
        end
        chk("t5_last_valid", {127'b0, msg_bus.o_msg_valid}, 128'd1);
        chk("t5_last_sev", {126'b0, msg_bus.o_msg_sev}, 128'b01);

        // Set beats clear, then reset with messages queued
        ready = 1'b0; sev = '0; en = 1'b1; vec = 7'b0000100; clr = 7'b0000100;
        tick();
        chk("t6_status", {121'b0, o_err_status}, 128'b0001100);
        en = 1'b0; vec = '0; clr = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_status", {121'b0, o_err_status}, 128'd0);
        chk("t6_rst_log", {127'b0, o_log_valid}, 128'd0);
        chk("t6_rst_ptr", {125'b0, o_first_err_ptr}, 128'd0);
        chk("t6_rst_hdr", o_hdr_log, 128'd0);
        chk("t6_rst_valid", {127'b0, msg_bus.o_msg_valid}, 128'd0);
        chk("t6_rst_sev", {126'b0, msg_bus.o_msg_sev}, 128'd0);
        chk("t6_rst_ovf", {127'b0, o_msg_overflow}, 128'd0);

        // Fatal reporting disabled: logged but no message
        sev_en = 3'b011; sev = {7{2'b10}}; en = 1'b1; vec = 7'b0000001; hdr = H1;
        tick();
        en = 1'b0; vec = '0;
        chk("t7_no_msg", {127'b0, msg_bus.o_msg_valid}, 128'd0);
        chk("t7_logged", {127'b0, o_log_valid}, 128'd1);
        repeat (3) tick();

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
